seg_bcd_scheduler: RTL and testbench

- Avalon-MM slave/master controller that sequences the team's 4-bit 7-segment digit PIOs.
- Software writes one binary value to the slave port. The block converts it to BCD with a sequential double-dabble, then issues one Avalon-MM master write per digit to the per-digit SEG PIO slaves.
- Sits between the Nios II data master (slave side) and the SEG PIO s1 ports (master side, through the interconnect).

---
 rtl/seg_bcd_scheduler.sv | 156 +++++++++++++++
 tb/tb_seg_bcd_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_bcd_scheduler.sv
// Avalon-MM controller: takes a binary value on the slave port, converts it to BCD
// with a sequential double-dabble, then writes one digit to each SEG PIO over the master port.

module bcd_nibble_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module seg_bcd_scheduler #(
    parameter int          NDIGITS    = 4,
    parameter int          BIN_W      = 13,
    parameter logic [31:0] SEG_BASE   = 32'h0000_0000,
    parameter logic [31:0] SEG_STRIDE = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] m_address,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        busy
);
    localparam int BCD_W = 4 * NDIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;

    state_t             state;
    logic [BIN_W-1:0]   value_reg;
    logic               pending;
    logic [BCD_W-1:0]   digits;
    logic [BIN_W-1:0]   bin_sh;
    logic [BCD_W-1:0]   bcd;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;
    logic               val_wr;
    logic [BIN_W-1:0]   start_val;
    logic               unused_bits;

    function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] v,
                                            input logic [IDX_W-1:0] i);
        digit_at = 4'd0;
        for (int k = 0; k < NDIGITS; k++)
            if (i == IDX_W'(k)) digit_at = v[4*k +: 4];
    endfunction

    generate
        for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
            bcd_nibble_adj u_adj (.din(bcd[4*g +: 4]), .dout(bcd_adj[4*g +: 4]));
        end
    endgenerate

    // One double-dabble step: the adjusted BCD and the binary shift left as a single register.
    assign bcd_next    = {bcd_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
    assign bin_next    = {bin_sh[BIN_W-2:0], 1'b0};
    assign val_wr      = chipselect & ~write_n & (address == 2'd0);
    assign start_val   = val_wr ? writedata[BIN_W-1:0] : value_reg;
    assign unused_bits = ^{writedata[31:BIN_W], bcd_adj[BCD_W-1]};

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[BIN_W-1:0] = value_reg;
            2'd1:    readdata[1:0]       = {pending, busy};
            2'd2:    readdata[BCD_W-1:0] = digits;
            default: readdata            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            value_reg   <= '0;
            pending     <= 1'b0;
            digits      <= '0;
            bin_sh      <= '0;
            bcd         <= '0;
            cnt         <= '0;
            idx         <= '0;
            m_write     <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
            busy        <= 1'b0;
        end else begin
            if (val_wr) value_reg <= writedata[BIN_W-1:0];
            case (state)
                IDLE: begin
                    if (val_wr) begin
                        state  <= CONVERT;
                        busy   <= 1'b1;
                        bin_sh <= start_val;
                        bcd    <= '0;
                        cnt    <= '0;
                    end
                end
                CONVERT: begin
                    if (val_wr) pending <= 1'b1;
                    bcd    <= bcd_next;
                    bin_sh <= bin_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state       <= WRITE;
                        idx         <= '0;
                        m_write     <= 1'b1;
                        m_address   <= SEG_BASE;
                        m_writedata <= {28'd0, bcd_next[3:0]};
                    end
                end
                WRITE: begin
                    if (val_wr) pending <= 1'b1;
                    if (!m_waitrequest) begin
                        if (idx != LAST_IDX) begin
                            idx         <= idx + 1'b1;
                            m_address   <= m_address + SEG_STRIDE;
                            m_writedata <= {28'd0, digit_at(bcd, idx + 1'b1)};
                        end else begin
                            state       <= DONE;
                            m_write     <= 1'b0;
                            m_address   <= '0;
                            m_writedata <= '0;
                        end
                    end
                end
                DONE: begin
                    digits <= bcd;
                    // A write landing on this cycle wins over the older pending value.
                    if (val_wr || pending) begin
                        state   <= CONVERT;
                        pending <= 1'b0;
                        bin_sh  <= start_val;
                        bcd     <= '0;
                        cnt     <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_bcd_scheduler.sv
// Bench for seg_bcd_scheduler: directed register/latency/stall/rerun/reset cases plus a
// random phase, all scored against a decimal-arithmetic model of the digit writes.

module tb_seg_bcd_scheduler;
    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic        busy;

    seg_bcd_scheduler dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] digit_of(input int v, input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p *= 10;
        return 32'((v / p) % 10);
    endfunction

    function automatic logic [31:0] bcd_of(input int v);
        logic [31:0] r = '0;
        for (int i = 0; i < ND; i++) r |= digit_of(v, i) << (4 * i);
        return r;
    endfunction

    // Model state: what the register file should show, plus queued digit writes.
    logic [31:0] exp_addr[$], exp_data[$], log_addr[$], log_data[$], want[$];
    logic [31:0] mdl_value = '0, mdl_digits = '0, rexp, hold_addr, hold_data;
    bit          mdl_pending = 0, mdl_busy = 0, in_done = 0, new_done, hold = 0, wr;
    int          acc_cnt = 0, run_val = 0, wv;

    task automatic push_run(input int v);
        run_val  = v;
        mdl_busy = 1;
        for (int i = 0; i < ND; i++) begin
            exp_addr.push_back(32'(i * 16));
            exp_data.push_back(digit_of(v, i));
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_addr.delete(); exp_data.delete();
            mdl_value = '0; mdl_digits = '0; mdl_pending = 0; mdl_busy = 0;
            in_done = 0; hold = 0; acc_cnt = 0;
        end else begin
            case (address)
                2'd0:    rexp = mdl_value;
                2'd1:    rexp = {30'd0, mdl_pending, mdl_busy};
                2'd2:    rexp = mdl_digits;
                default: rexp = '0;
            endcase
            chk("readdata", readdata, rexp);
            chk("busy", 32'(busy), 32'(mdl_busy));
            if (!mdl_busy) chk("m_write_while_idle", 32'(m_write), 32'd0);
            if (hold) begin
                chk("stall_m_write", 32'(m_write), 32'd1);
                chk("stall_m_address", m_address, hold_addr);
                chk("stall_m_writedata", m_writedata, hold_data);
            end
            hold = m_write && m_waitrequest;
            hold_addr = m_address;
            hold_data = m_writedata;

            new_done = 0;
            if (m_write && !m_waitrequest) begin
                log_addr.push_back(m_address);
                log_data.push_back(m_writedata);
                if (exp_addr.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want none", m_address, m_writedata);
                end else begin
                    chk("write_addr", m_address, exp_addr.pop_front());
                    chk("write_data", m_writedata, exp_data.pop_front());
                end
                acc_cnt++;
                if (acc_cnt == ND) begin new_done = 1; acc_cnt = 0; end
            end

            wr = chipselect && !write_n && address == 2'd0;
            wv = int'(writedata & 32'h1FFF);
            if (wr) mdl_value = 32'(wv);
            if (in_done) begin
                mdl_digits = bcd_of(run_val);
                if (wr)               begin push_run(wv);               mdl_pending = 0; end
                else if (mdl_pending) begin push_run(int'(mdl_value));  mdl_pending = 0; end
                else mdl_busy = 0;
            end else if (wr) begin
                if (mdl_busy) mdl_pending = 1;
                else push_run(wv);
            end
            in_done = new_done;
        end
    end

    task automatic write_value(input logic [31:0] d, output int wc);
        @(posedge clk); #1;
        chipselect = 1; write_n = 0; address = 2'd0; writedata = d;
        @(posedge clk); #1;
        wc = cyc;
        chipselect = 0; write_n = 1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        address = a; chipselect = 1; write_n = 1;
        @(negedge clk);
        d = readdata;
        @(posedge clk); #1;
        chipselect = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((busy || m_write) && k < 400) begin @(negedge clk); k++; end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_log(input string nm);
        logic [31:0] got;
        chk({nm, "_count"}, 32'(log_data.size()), 32'(want.size()));
        for (int i = 0; i < want.size(); i++) begin
            got = (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
            chk({nm, "_data"}, got, want[i]);
            got = (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF;
            chk({nm, "_addr"}, got, 32'((i % ND) * 16));
        end
    endtask

    task automatic run_case(input string nm, input logic [31:0] d);
        int wc;
        log_addr.delete(); log_data.delete();
        write_value(d, wc);
        wait_idle();
        check_log(nm);
    endtask

    initial begin
        logic [31:0] d;
        int wc, first, mw;
        reset_n = 0; address = 0; chipselect = 0; write_n = 1; writedata = 0; m_waitrequest = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        for (int a = 0; a < 4; a++) begin rd(2'(a), d); chk("reset_read", d, 32'd0); end
        chk("reset_m_write", 32'(m_write), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // 1234 with no stalls: latency and digit order
        log_addr.delete(); log_data.delete();
        write_value(32'd1234, wc);
        for (int k = 0; k < 40; k++) begin @(negedge clk); if (m_write) break; end
        first = cyc;
        chk("first_write_latency", 32'(first - wc), 32'd13);
        wait_idle();
        want = '{32'd4, 32'd3, 32'd2, 32'd1};
        check_log("v1234");
        rd(2'd2, d); chk("digits_1234", d, 32'h1234);
        chk("busy_after_done", 32'(busy), 32'd0);

        want = '{32'd0, 32'd0, 32'd0, 32'd0};
        run_case("v0", 32'd0);
        want = '{32'd1, 32'd9, 32'd1, 32'd8};
        run_case("v8191", 32'd8191);
        want = '{32'd5, 32'd0, 32'd0, 32'd0};
        run_case("upper_bits", 32'hFFFF_E005);
        rd(2'd0, d); chk("value_masked", d, 32'h5);

        // Three-cycle stall on the digit-1 write
        log_addr.delete(); log_data.delete();
        write_value(32'd1234, wc);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (m_write && m_address == 32'h10) break;
        end
        m_waitrequest = 1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_addr", m_address, 32'h10);
            chk("stall_data", m_writedata, 32'd3);
            @(posedge clk); #1;
        end
        m_waitrequest = 0;
        @(negedge clk);
        chk("stall_release_addr", m_address, 32'h10);
        chk("stall_release_data", m_writedata, 32'd3);
        wait_idle();
        want = '{32'd4, 32'd3, 32'd2, 32'd1};
        check_log("stall");

        // Writes while converting collapse to a single rerun of the last value
        log_addr.delete(); log_data.delete();
        write_value(32'd1234, wc);
        write_value(32'd42, wc);
        write_value(32'd77, wc);
        rd(2'd1, d); chk("status_pending", d, 32'd3);
        wait_idle();
        want = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd7, 32'd7, 32'd0, 32'd0};
        check_log("rerun");
        rd(2'd2, d); chk("digits_rerun", d, 32'h0077);
        rd(2'd0, d); chk("value_rerun", d, 32'd77);

        // Reset during the digit-2 write
        log_addr.delete(); log_data.delete();
        write_value(32'd1234, wc);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (m_write && m_address == 32'h20) break;
        end
        #2 reset_n = 0;
        #1 chk("async_reset_m_write", 32'(m_write), 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
        @(posedge clk); @(posedge clk); #1 reset_n = 1;
        for (int a = 0; a < 4; a++) begin rd(2'(a), d); chk("post_reset_read", d, 32'd0); end
        mw = 0;
        repeat (20) begin @(negedge clk); if (m_write) mw++; end
        chk("no_write_after_reset", 32'(mw), 32'd0);
        chk("aborted_log_count", 32'(log_data.size()), 32'd2);

        // Random traffic: stalls, reads, writes to every address, collisions with busy/DONE
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            m_waitrequest = ($urandom_range(0, 3) == 0);
            chipselect    = ($urandom_range(0, 11) == 0);
            write_n       = 1'($urandom_range(0, 1));
            address       = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            writedata     = $urandom;
        end
        @(posedge clk); #1;
        chipselect = 0; write_n = 1; m_waitrequest = 0;
        wait_idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_addr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
